// File: rtl/seq_shift_add_mult_if.sv
// rtl/seq_shift_add_mult_if.sv - start/busy/done handshake and operand/product bus for the shift-add multiplier
interface seq_shift_add_mult_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - unsigned N x N sequential shift-and-add multiplier around one ripple adder
// Optional macro MULT_EARLY_EXIT_EN: zero operand skips the RUN iterations and finishes in one cycle.
module param_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N];
endmodule

module seq_shift_add_mult #(
  parameter int N = 4
) (
  input logic                clk,
  input logic                rst,
  seq_shift_add_mult_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   mcand;
  logic [N-1:0]   acc_hi;
  logic [N-1:0]   acc_lo;
  logic [CW-1:0]  count;
  logic [2*N-1:0] product_q;
  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic           accept;
  logic           last_iter;
  logic           zero_op;
  logic           busy;
  logic           done;
  logic [2*N-1:0] shifted;

  assign addend = acc_lo[0] ? mcand : '0;

  param_adder #(.N(N)) u_adder (
    .a    (acc_hi),
    .b    (addend),
    .c_in (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Carry-out becomes the new MSB so the full (N+1)-bit add survives the shift.
  assign shifted   = {cout, sum, acc_lo[N-1:1]};
  assign accept    = (state == IDLE) && bus.start;
  assign last_iter = (count == CW'(N - 1));

`ifdef MULT_EARLY_EXIT_EN
  assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      count     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand  <= bus.a;
      acc_hi <= '0;
      acc_lo <= bus.b;
      count  <= '0;
      if (zero_op) begin
        product_q <= '0;
      end
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= shifted;
      count            <= count + 1'b1;
      if (last_iter) begin
        product_q <= shifted;
      end
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb/tb_seq_shift_add_mult.sv - randomized self-checking bench for seq_shift_add_mult at N=4 and N=8
module tb_seq_shift_add_mult;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  int   cnt;
  logic seen;

  always #5 clk = ~clk;

  seq_shift_add_mult_if #(.N(4)) bus4 ();
  seq_shift_add_mult_if #(.N(8)) bus8 ();

  seq_shift_add_mult #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_shift_add_mult #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the accepting edge (inclusive) until done is visible.
  function automatic int exp_lat(input int n, input int x, input int y);
    return (EARLY && (x == 0 || y == 0)) ? 1 : n + 1;
  endfunction

  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input string tag);
    int lat;
    int expp;
    expp = int'(x) * int'(y);
    bus4.a = x;
    bus4.b = y;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    bus4.a = 4'($urandom);
    bus4.b = 4'($urandom);
    check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
    lat = 1;
    while (!bus4.done && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(4, int'(x), int'(y))));
    check({tag, "_prod"}, 32'(bus4.product), 32'(expp));
    step();
    check({tag, "_pulse"}, 32'(bus4.done), 32'd0);
    check({tag, "_idle"}, 32'(bus4.busy), 32'd0);
    check({tag, "_hold"}, 32'(bus4.product), 32'(expp));
  endtask

  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input string tag);
    int lat;
    int expp;
    expp = int'(x) * int'(y);
    bus8.a = x;
    bus8.b = y;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    lat = 1;
    while (!bus8.done && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(8, int'(x), int'(y))));
    check({tag, "_prod"}, 32'(bus8.product), 32'(expp));
    step();
    check({tag, "_pulse"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_busy4", 32'(bus4.busy), 32'd0);
    check("rst_done4", 32'(bus4.done), 32'd0);
    check("rst_prod4", 32'(bus4.product), 32'd0);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_done8", 32'(bus8.done), 32'd0);
    check("rst_prod8", 32'(bus8.product), 32'd0);
    rst = 1'b0;
    step();

    mul4(4'd13, 4'd11, "t1");
    mul4(4'd15, 4'd15, "t2");
    mul4(4'd0, 4'd9, "t3a");
    mul4(4'd5, 4'd0, "t3b");

    // Starts during RUN and DONE must be ignored.
    bus4.a = 4'd7;
    bus4.b = 4'd6;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    step();
    bus4.a = 4'd1;
    bus4.b = 4'd1;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    cnt = 0;
    while (!bus4.done && cnt < 40) begin
      step();
      cnt++;
    end
    check("t4_done", 32'(bus4.done), 32'd1);
    check("t4_prod", 32'(bus4.product), 32'd42);
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    check("t4_after_done_busy", 32'(bus4.busy), 32'd0);
    check("t4_after_done_pulse", 32'(bus4.done), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      step();
      if (bus4.done) seen = 1'b1;
    end
    check("t4_no_extra_done", 32'(seen), 32'd0);
    check("t4_prod_held", 32'(bus4.product), 32'd42);
    mul4(4'd2, 4'd3, "t4_next");

    // Reset on the second RUN cycle aborts the operation.
    bus4.a = 4'd9;
    bus4.b = 4'd5;
    bus4.start = 1'b1;
    step();
    bus4.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", 32'(bus4.busy), 32'd0);
    check("t5_done", 32'(bus4.done), 32'd0);
    check("t5_prod", 32'(bus4.product), 32'd0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (bus4.done) seen = 1'b1;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    mul4(4'd9, 4'd5, "t5_retry");

    for (int i = 0; i < 20; i++) begin
      mul4(4'($urandom), 4'($urandom), "r4");
    end

    mul8(8'd255, 8'd255, "t6");
    mul8(8'd0, 8'd200, "t6_zero");
    for (int i = 0; i < 100; i++) begin
      mul8(8'($urandom), 8'($urandom), "r8");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
